// File: rtl/roll_sequencer.sv
// Die-roll control FSM: latches a die request, gates the SIPO random source,
// rejects out-of-range words, reduces by repeated subtraction and hands the face to the UART.
module roll_sequencer #(
  parameter int DATA_W    = 7,
  parameter int MAX_RETRY = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        i_dieSelect,
  input  logic [DATA_W-1:0] i_randomData,
  input  logic              i_valid,
  output logic              o_stop,
  output logic [4:0]        o_dieRoll,
  output logic              o_roll_valid,
  output logic [7:0]        o_tx_data,
  output logic              o_tx_valid,
  input  logic              i_tx_ready,
  output logic              o_error
);

  typedef enum logic [2:0] {IDLE, WAIT_RAND, CHECK, REDUCE, SEND, RELEASE} stateT;

  localparam int RANGE = 2 ** DATA_W;
  localparam logic [DATA_W:0] LIM_D4  = (DATA_W+1)'(RANGE - RANGE % 4);
  localparam logic [DATA_W:0] LIM_D6  = (DATA_W+1)'(RANGE - RANGE % 6);
  localparam logic [DATA_W:0] LIM_D8  = (DATA_W+1)'(RANGE - RANGE % 8);
  localparam logic [DATA_W:0] LIM_D10 = (DATA_W+1)'(RANGE - RANGE % 10);
  localparam logic [DATA_W:0] LIM_D12 = (DATA_W+1)'(RANGE - RANGE % 12);
  localparam logic [DATA_W:0] LIM_D20 = (DATA_W+1)'(RANGE - RANGE % 20);

  stateT             state;
  logic [DATA_W-1:0] acc;
  logic [4:0]        sides;
  logic [DATA_W:0]   limit;
  logic [3:0]        retryCount;

  // A zero face count marks an illegal or empty request code.
  function automatic logic [4:0] sidesOf(input logic [3:0] code);
    case (code)
      4'd1:    sidesOf = 5'd4;
      4'd2:    sidesOf = 5'd6;
      4'd3:    sidesOf = 5'd8;
      4'd4:    sidesOf = 5'd10;
      4'd5:    sidesOf = 5'd12;
      4'd6:    sidesOf = 5'd20;
      default: sidesOf = 5'd0;
    endcase
  endfunction

  function automatic logic [DATA_W:0] limitOf(input logic [3:0] code);
    case (code)
      4'd1:    limitOf = LIM_D4;
      4'd2:    limitOf = LIM_D6;
      4'd3:    limitOf = LIM_D8;
      4'd4:    limitOf = LIM_D10;
      4'd5:    limitOf = LIM_D12;
      4'd6:    limitOf = LIM_D20;
      default: limitOf = '0;
    endcase
  endfunction

  assign o_tx_data = {3'b000, o_dieRoll};

  // o_stop is registered from the next state: the SIPO only runs while waiting for a word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      o_stop       <= 1'b1;
      o_dieRoll    <= '0;
      o_roll_valid <= 1'b0;
      o_tx_valid   <= 1'b0;
      o_error      <= 1'b0;
      retryCount   <= '0;
      acc          <= '0;
      sides        <= '0;
      limit        <= '0;
    end else begin
      o_roll_valid <= 1'b0;
      case (state)
        IDLE: begin
          o_stop <= 1'b1;
          if (sidesOf(i_dieSelect) != 5'd0) begin
            sides      <= sidesOf(i_dieSelect);
            limit      <= limitOf(i_dieSelect);
            retryCount <= '0;
            o_error    <= 1'b0;
            o_stop     <= 1'b0;
            state      <= WAIT_RAND;
          end
        end
        WAIT_RAND: begin
          if (i_valid) begin
            acc    <= i_randomData;
            o_stop <= 1'b1;
            state  <= CHECK;
          end
        end
        CHECK: begin
          if ({1'b0, acc} >= limit) begin
            retryCount <= retryCount + 4'd1;
            if (retryCount + 4'd1 == 4'(MAX_RETRY)) begin
              o_error <= 1'b1;
              state   <= RELEASE;
            end else begin
              o_stop <= 1'b0;
              state  <= WAIT_RAND;
            end
          end else begin
            state <= REDUCE;
          end
        end
        REDUCE: begin
          if (acc >= DATA_W'(sides)) begin
            acc <= acc - DATA_W'(sides);
          end else begin
            o_dieRoll    <= acc[4:0] + 5'd1;
            o_roll_valid <= 1'b1;
            o_tx_valid   <= 1'b1;
            state        <= SEND;
          end
        end
        SEND: begin
          if (i_tx_ready) begin
            o_tx_valid <= 1'b0;
            state      <= RELEASE;
          end
        end
        RELEASE: begin
          if (i_dieSelect == 4'd0) state <= IDLE;
        end
        default: begin
          o_stop <= 1'b1;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_roll_sequencer.sv
// Directed scoreboard bench for roll_sequencer: expected faces/latencies are pushed
// when a random word is strobed and popped when the DUT pulses o_roll_valid.
module tb_roll_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] i_dieSelect;
  logic [6:0] i_randomData;
  logic       i_valid;
  logic       i_tx_ready;
  logic       o_stop, o_roll_valid, o_tx_valid, o_error;
  logic [4:0] o_dieRoll;
  logic [7:0] o_tx_data;

  logic [3:0] sel2;
  logic [6:0] rand2;
  logic       valid2;
  logic       ready2;
  logic       stop2, rollValid2, txValid2, error2;
  logic [4:0] dieRoll2;
  logic [7:0] txData2;

  typedef struct {int face; int latency;} expT;
  expT sbQueue[$];

  int compareCount = 0;
  int errCount = 0;

  always #5 clk = ~clk;

  roll_sequencer #(.DATA_W(7), .MAX_RETRY(8)) dut (
    .clk(clk), .reset(reset), .i_dieSelect(i_dieSelect), .i_randomData(i_randomData),
    .i_valid(i_valid), .o_stop(o_stop), .o_dieRoll(o_dieRoll), .o_roll_valid(o_roll_valid),
    .o_tx_data(o_tx_data), .o_tx_valid(o_tx_valid), .i_tx_ready(i_tx_ready), .o_error(o_error)
  );

  roll_sequencer #(.DATA_W(7), .MAX_RETRY(2)) dut2 (
    .clk(clk), .reset(reset), .i_dieSelect(sel2), .i_randomData(rand2),
    .i_valid(valid2), .o_stop(stop2), .o_dieRoll(dieRoll2), .o_roll_valid(rollValid2),
    .o_tx_data(txData2), .o_tx_valid(txValid2), .i_tx_ready(ready2), .o_error(error2)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compareCount++;
    assert (observed === expected) else begin
      errCount++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] code);
    i_dieSelect = code;
    step();
    checkOutput("stopLowAfterRequest", o_stop, 1'b0);
  endtask

  task automatic sendRandom(input logic [6:0] r);
    i_randomData = r;
    i_valid = 1'b1;
    step();
    i_valid = 1'b0;
  endtask

  // Independent reference: rejection by range limit, face by modulo, latency by quotient.
  task automatic rollOnce(input int r, input int n);
    if (r < (128 / n) * n) sbQueue.push_back('{r % n + 1, r / n + 2});
    sendRandom(7'(r));
  endtask

  task automatic waitRoll();
    int cycles = 0;
    expT e;
    while (!o_roll_valid && cycles < 100) begin
      step();
      cycles++;
    end
    if (sbQueue.size() == 0) begin
      checkOutput("scoreboardUnderflow", 32'd1, 32'd0);
      return;
    end
    e = sbQueue.pop_front();
    checkOutput("rollLatency", 32'(cycles), 32'(e.latency));
    checkOutput("dieRoll", 32'(o_dieRoll), 32'(e.face));
    checkOutput("txData", 32'(o_tx_data), 32'(e.face));
    checkOutput("txValidAtRoll", o_tx_valid, 1'b1);
    step();
    checkOutput("rollValidOnePulse", o_roll_valid, 1'b0);
  endtask

  task automatic completeTx();
    checkOutput("txValidBeforeReady", o_tx_valid, 1'b1);
    i_tx_ready = 1'b1;
    step();
    i_tx_ready = 1'b0;
    checkOutput("txValidAfterReady", o_tx_valid, 1'b0);
  endtask

  task automatic releaseButton();
    i_dieSelect = 4'd0;
    step();
    step();
    checkOutput("stopHighIdle", o_stop, 1'b1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL globalTimeout: observed running expected finished");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic stable;
    logic quiet;
    reset = 1'b1;
    i_dieSelect = '0; i_randomData = '0; i_valid = 1'b0; i_tx_ready = 1'b0;
    sel2 = '0; rand2 = '0; valid2 = 1'b0; ready2 = 1'b1;
    repeat (3) step();
    checkOutput("resetStop", o_stop, 1'b1);
    checkOutput("resetDieRoll", 32'(o_dieRoll), 32'd0);
    checkOutput("resetRollValid", o_roll_valid, 1'b0);
    checkOutput("resetTxData", 32'(o_tx_data), 32'd0);
    checkOutput("resetTxValid", o_tx_valid, 1'b0);
    checkOutput("resetError", o_error, 1'b0);
    reset = 1'b0;
    step();
    checkOutput("idleStop", o_stop, 1'b1);

    // D6, r=45 -> face 4 after 9 cycles
    applyStimulus(4'd2);
    rollOnce(45, 6);
    waitRoll();
    completeTx();
    releaseButton();

    // D10, r=125 rejected, then r=7 -> face 8
    applyStimulus(4'd4);
    rollOnce(125, 10);
    checkOutput("stopHighInCheck", o_stop, 1'b1);
    step();
    checkOutput("stopLowAfterReject", o_stop, 1'b0);
    rollOnce(7, 10);
    waitRoll();
    checkOutput("noErrorAfterOneReject", o_error, 1'b0);
    completeTx();
    releaseButton();

    // D20 upper boundary and D4 longest reduction
    applyStimulus(4'd6);
    rollOnce(119, 20);
    waitRoll();
    completeTx();
    releaseButton();
    applyStimulus(4'd1);
    rollOnce(127, 4);
    waitRoll();
    completeTx();
    releaseButton();

    // D8 with a stalled transmitter and the button held throughout
    applyStimulus(4'd3);
    rollOnce(99, 8);
    waitRoll();
    for (int i = 0; i < 50; i++) begin
      step();
      if (i % 10 == 9) begin
        checkOutput("stallTxValid", o_tx_valid, 1'b1);
        checkOutput("stallTxData", 32'(o_tx_data), 32'd4);
      end
    end
    completeTx();
    quiet = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (i == 5) sendRandom(7'd3);
      else step();
      if (o_roll_valid || o_tx_valid || !o_stop) quiet = 1'b0;
    end
    checkOutput("noSecondRollWhileHeld", quiet, 1'b1);
    releaseButton();

    // Select change after the request is latched is ignored: D12 stays in force
    applyStimulus(4'd5);
    i_dieSelect = 4'd6;
    rollOnce(30, 12);
    waitRoll();
    completeTx();
    releaseButton();

    // Reset in the middle of REDUCE discards the roll
    applyStimulus(4'd1);
    sendRandom(7'd127);
    repeat (10) step();
    #3;
    reset = 1'b1;
    #1;
    checkOutput("asyncResetStop", o_stop, 1'b1);
    checkOutput("asyncResetTxValid", o_tx_valid, 1'b0);
    checkOutput("asyncResetDieRoll", 32'(o_dieRoll), 32'd0);
    i_dieSelect = 4'd0;
    step();
    reset = 1'b0;
    stable = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step();
      if (o_roll_valid || o_tx_valid || !o_stop) stable = 1'b0;
    end
    checkOutput("noRollAfterReset", stable, 1'b1);
    applyStimulus(4'd2);
    rollOnce(5, 6);
    waitRoll();
    completeTx();
    releaseButton();

    // MAX_RETRY=2 instance: two rejects raise the error, a new request clears it
    sel2 = 4'd2;
    step();
    checkOutput("d2StopLow", stop2, 1'b0);
    rand2 = 7'd126; valid2 = 1'b1; step(); valid2 = 1'b0;
    step();
    checkOutput("d2FirstRejectStop", stop2, 1'b0);
    checkOutput("d2FirstRejectError", error2, 1'b0);
    rand2 = 7'd127; valid2 = 1'b1; step(); valid2 = 1'b0;
    step();
    checkOutput("d2ErrorSet", error2, 1'b1);
    checkOutput("d2ErrorStop", stop2, 1'b1);
    quiet = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      if (txValid2 || rollValid2) quiet = 1'b0;
    end
    checkOutput("d2NoTx", quiet, 1'b1);
    checkOutput("d2ErrorSticky", error2, 1'b1);
    sel2 = 4'd0;
    step();
    step();
    sel2 = 4'd1;
    step();
    checkOutput("d2ErrorCleared", error2, 1'b0);
    checkOutput("d2StopLowAgain", stop2, 1'b0);
    rand2 = 7'd0; valid2 = 1'b1; step(); valid2 = 1'b0;
    step();
    step();
    checkOutput("d2RollValid", rollValid2, 1'b1);
    checkOutput("d2DieRoll", 32'(dieRoll2), 32'd1);
    checkOutput("d2TxData", 32'(txData2), 32'd1);
    step();
    checkOutput("d2TxDone", txValid2, 1'b0);
    sel2 = 4'd0;
    step();

    checkOutput("scoreboardDrained", 32'(sbQueue.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, errCount);
    $finish;
  end

endmodule
